// File: rtl/onchip_mem_pkg.sv
// Shared types and default dimensions for the on-chip memory master.
package onchip_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 11;
  localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_e;

endpackage

// File: rtl/onchip_mem_rd_skid.sv
// Two-entry read-return buffer; absorbs the one-cycle RAM latency against rd_ready stalls.
module onchip_mem_rd_skid
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/onchip_mem_master.sv
// Command-driven burst master for a single-port on-chip RAM (Avalon-MM, 1-cycle read latency).
// Define ONCHIP_MEM_MASTER_RANGECHK_EN to reject commands running past the RAM top via err.
module onchip_mem_master
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
  ,
  output logic                err
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic                drain_done;
  logic                rd_pop;
  logic [1:0]          rd_cnt;
  logic                can_issue;

`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  logic             err_q, err_d;
  logic [SUM_W-1:0] cmd_end;
  logic             out_of_range;

  assign cmd_end      = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign out_of_range = cmd_end > (SUM_W'(1) << ADDR_W);
  assign err          = err_q;
`endif

  assign rd_pop = rd_valid && rd_ready;
  // Buffered plus in-flight words, less this cycle's pop, must leave room for one more.
  assign can_issue = ({1'b0, rd_cnt} + {2'b0, pend_q}) < (3'd2 + {2'b0, rd_pop});

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    be_d           = be_q;
    done_d         = 1'b0;
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
    err_d          = 1'b0;
`endif
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    drain_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          be_d   = cmd_byteenable;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
          else if (out_of_range) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
`endif
          else if (cmd_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          avm_chipselect = 1'b1;
          avm_write      = 1'b1;
          addr_d         = addr_q + ADDR_W'(1);
          len_d          = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (can_issue) begin
          avm_chipselect = 1'b1;
          addr_d         = addr_q + ADDR_W'(1);
          len_d          = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The final word leaves the buffer this cycle: completion coincides with it.
        if (!pend_q && (rd_cnt == 2'd1) && rd_pop) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pend_d = avm_chipselect && !avm_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      be_q    <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      be_q    <= be_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
      err_q   <= err_d;
`endif
    end
  end

  onchip_mem_rd_skid #(
    .DATA_W (DATA_W)
  ) u_rd_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (pend_q),
    .push_data_i (avm_readdata),
    .pop_i       (rd_pop),
    .valid_o     (rd_valid),
    .data_o      (rd_data),
    .count_o     (rd_cnt)
  );

  assign done           = done_q || drain_done;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wr_data;
  assign avm_clken      = reset_n;

endmodule

// File: tb/tb_onchip_mem_master.sv
// Directed self-checking bench for onchip_mem_master against a 1-cycle-latency RAM model.
// Honours ONCHIP_MEM_MASTER_RANGECHK_EN for the range-check scenario.
module tb_onchip_mem_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [3:0]  cmd_byteenable;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic [9:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_clken;
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
  logic        err;
`endif

  int total;
  int bad;

  logic [31:0] ram [0:onchip_mem_pkg::RAM_DEPTH-1];
  int          doneCount;
  int          csCount;
  int          issueCount;
  int          popCount;
  logic [31:0] popLog [0:63];

  onchip_mem_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_byteenable (cmd_byteenable),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .done           (done),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_clken      (avm_clken)
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
    ,.err           (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: byte-enabled writes, registered read data one cycle after the access.
  always @(posedge clk) begin
    if (avm_chipselect === 1'b1 && avm_clken === 1'b1) begin
      if (avm_write === 1'b1) begin
        for (int b = 0; b < 4; b++) begin
          if (avm_byteenable[b]) ram[avm_address][b*8 +: 8] <= avm_writedata[b*8 +: 8];
        end
      end else begin
        avm_readdata <= ram[avm_address];
      end
    end
  end

  // Event log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
    if (avm_chipselect === 1'b1) begin
      csCount++;
      if (avm_write !== 1'b1) issueCount++;
    end
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      popLog[popCount % 64] = rd_data;
      popCount++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [10:0] l, input logic [3:0] be);
    int n = 0;
    cmd_write      = w;
    cmd_addr       = a;
    cmd_len        = l;
    cmd_byteenable = be;
    cmd_valid      = 1'b1;
    #1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("[TB] FAIL cmd_accept got=timeout exp=cmd_ready");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [9:0] a, input logic [10:0] l, input logic [31:0] base);
    send_cmd(1'b1, a, l, 4'hF);
    for (int k = 0; k < int'(l); k++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(k);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    #1;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL burst_done got=%0b exp=1", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_byteenable = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #3;
    total++;
    if (avm_clken !== 1'b0 || avm_chipselect !== 1'b0 || avm_write !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_avm got=clken%0b cs%0b wr%0b exp=000", avm_clken, avm_chipselect, avm_write);
    end
    total++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outs got=rdv%0b done%0b exp=00", rd_valid, done);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || avm_clken !== 1'b1 || wr_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL release got=rdy%0b clken%0b wrr%0b exp=110", cmd_ready, avm_clken, wr_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    int cs0 = csCount;
    int d0  = doneCount;
    send_cmd(1'b1, 10'd7, 11'd0, 4'hF);
    #1;
    total++;
    if (done !== 1'b1 || avm_chipselect !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zlen_done got=done%0b cs%0b exp=done1 cs0", done, avm_chipselect);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL zlen_after got=done%0b rdy%0b exp=done0 rdy1", done, cmd_ready);
    end
    total++;
    if (csCount != cs0 || doneCount - d0 != 1) begin
      bad++;
      $display("[TB] FAIL zlen_counts got=cs%0d dn%0d exp=cs0 dn1", csCount - cs0, doneCount - d0);
    end
  endtask

  task automatic test_write();
    send_cmd(1'b1, 10'd5, 11'd4, 4'hF);
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA0 + 32'(k);
      #1;
      total++;
      if (wr_ready !== 1'b1 || avm_chipselect !== 1'b1 || avm_write !== 1'b1 ||
          avm_address !== 10'(5 + k) || avm_writedata !== 32'hA0 + 32'(k) || avm_byteenable !== 4'hF) begin
        bad++;
        $display("[TB] FAIL write_beat%0d got=rdy%0b cs%0b w%0b a%0d d%h be%h exp=1 1 1 a%0d d%h beF", k,
                 wr_ready, avm_chipselect, avm_write, avm_address, avm_writedata, avm_byteenable, 5 + k, 32'hA0 + k);
      end
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL write_early_done beat%0d got=%0b exp=0", k, done);
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    #1;
    total++;
    if (done !== 1'b1 || wr_ready !== 1'b0 || avm_chipselect !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_done got=done%0b wrr%0b cs%0b exp=100", done, wr_ready, avm_chipselect);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL write_after got=done%0b rdy%0b exp=01", done, cmd_ready);
    end
  endtask

  task automatic test_read();
    logic expCs, expV, expDone;
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'd5, 11'd4, 4'hF);
    for (int k = 0; k < 7; k++) begin
      #1;
      expCs   = (k < 4);
      expV    = (k >= 2 && k <= 5);
      expDone = (k == 5);
      total++;
      if (avm_chipselect !== expCs || avm_write !== 1'b0 || (expCs && avm_address !== 10'(5 + k))) begin
        bad++;
        $display("[TB] FAIL read_issue k%0d got=cs%0b w%0b a%0d exp=cs%0b w0 a%0d", k,
                 avm_chipselect, avm_write, avm_address, expCs, 5 + k);
      end
      total++;
      if (rd_valid !== expV || (expV && rd_data !== 32'hA0 + 32'(k - 2)) || done !== expDone) begin
        bad++;
        $display("[TB] FAIL read_data k%0d got=v%0b d%h done%0b exp=v%0b d%h done%0b", k,
                 rd_valid, rd_data, done, expV, 32'hA0 + 32'(k - 2), expDone);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_read_throttle();
    int base, d0, n, maxOut;
    write_burst(10'd100, 11'd8, 32'h100);
    base = popCount;
    d0   = doneCount;
    maxOut = 0;
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'd100, 11'd8, 4'hF);
    n = 0;
    while (doneCount == d0 && n < 100) begin
      rd_ready = (n % 2 == 0) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (issueCount - popCount > maxOut) maxOut = issueCount - popCount;
      n++;
    end
    rd_ready = 1'b1;
    total++;
    if (doneCount - d0 != 1) begin
      bad++;
      $display("[TB] FAIL throttle_done got=%0d exp=1", doneCount - d0);
    end
    total++;
    if (popCount - base != 8) begin
      bad++;
      $display("[TB] FAIL throttle_count got=%0d exp=8", popCount - base);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (popLog[(base + i) % 64] !== 32'h100 + 32'(i)) begin
        bad++;
        $display("[TB] FAIL throttle_word%0d got=%h exp=%h", i, popLog[(base + i) % 64], 32'h100 + i);
      end
    end
    total++;
    if (maxOut > 2) begin
      bad++;
      $display("[TB] FAIL throttle_occupancy got=%0d exp=<=2", maxOut);
    end
  endtask

  task automatic test_wrap();
`ifdef ONCHIP_MEM_MASTER_RANGECHK_EN
    int cs0 = csCount;
    send_cmd(1'b1, 10'd1022, 11'd4, 4'hF);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD;
    #1;
    total++;
    if (err !== 1'b1 || done !== 1'b1 || avm_chipselect !== 1'b0) begin
      bad++;
      $display("[TB] FAIL range_err got=err%0b done%0b cs%0b exp=110", err, done, avm_chipselect);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    #1;
    total++;
    if (err !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || csCount != cs0) begin
      bad++;
      $display("[TB] FAIL range_after got=err%0b done%0b rdy%0b cs%0d exp=0 0 1 cs0", err, done, cmd_ready, csCount - cs0);
    end
    @(posedge clk); #1;
`else
    logic [9:0] expA;
    send_cmd(1'b1, 10'd1022, 11'd4, 4'hF);
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hC0 + 32'(k);
      expA     = 10'(1022 + k);
      #1;
      total++;
      if (avm_chipselect !== 1'b1 || avm_address !== expA) begin
        bad++;
        $display("[TB] FAIL wrap_addr%0d got=cs%0b a%0d exp=cs1 a%0d", k, avm_chipselect, avm_address, expA);
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    #1;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_done got=%0b exp=1", done);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    int base, d0, n;
    rd_ready = 1'b1;
    base = popCount;
    d0   = doneCount;
    send_cmd(1'b0, 10'd100, 11'd8, 4'hF);
    n = 0;
    while (popCount - base < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (popCount - base != 3) begin
      bad++;
      $display("[TB] FAIL midrst_pops got=%0d exp=3", popCount - base);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (avm_chipselect !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0 || avm_clken !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_now got=cs%0b rdv%0b done%0b clken%0b exp=0000", avm_chipselect, rd_valid, done, avm_clken);
    end
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || rd_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midrst_hold got=done%0b rdv%0b exp=00", done, rd_valid);
      end
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || doneCount != d0) begin
      bad++;
      $display("[TB] FAIL midrst_release got=rdy%0b dn%0d exp=rdy1 dn0", cmd_ready, doneCount - d0);
    end
    @(posedge clk); #1;
    base = popCount;
    d0   = doneCount;
    send_cmd(1'b0, 10'd5, 11'd1, 4'hF);
    n = 0;
    while (doneCount == d0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (doneCount - d0 != 1 || popCount - base != 1 || popLog[base % 64] !== 32'hA0) begin
      bad++;
      $display("[TB] FAIL midrst_next got=dn%0d pops%0d d%h exp=dn1 pops1 dA0", doneCount - d0, popCount - base, popLog[base % 64]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero_len();
    test_write();
    test_read();
    test_read_throttle();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_master.md
ONCHIP_MEM_MASTER -- requirements
Module: onchip_mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the target RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter LEN_W, default 11, transfer-length width (1..1024 words).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_W start word; cmd_len in LEN_W word count; cmd_byteenable in 4, applied to every write.
REQ-006 SHALL have write-data stream: wr_valid in 1; wr_ready out 1; wr_data in 32.
REQ-007 SHALL have read-data stream: rd_valid out 1; rd_ready in 1; rd_data out 32.
REQ-008 SHALL have done out 1, one-cycle pulse at command completion.
REQ-009 SHALL have Avalon-MM master ports to the single-port RAM: avm_address out ADDR_W; avm_byteenable out 4; avm_chipselect out 1; avm_write out 1; avm_writedata out 32; avm_readdata in 32; avm_clken out 1.

Function
REQ-010 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-011 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&cmd_ready, latching addr, len, byteenable.
REQ-012 SHALL, on accept with cmd_len=0, pulse done next cycle, issue no access, stay IDLE.
REQ-013 SHALL, on accept with cmd_len>0, go to WRITE (cmd_write=1) or READ (cmd_write=0).
REQ-014 SHALL in WRITE drive wr_ready=1; each wr_valid cycle drives avm_chipselect=1, avm_write=1, avm_writedata=wr_data, current address, latched byteenable, same cycle (combinational).
REQ-015 SHALL issue read (avm_chipselect=1, avm_write=0) in READ only when buffered+in-flight-pop < 2; RAM read latency is exactly 1 cycle, avm_readdata captured on the cycle after issue.
REQ-016 SHALL buffer read data in a 2-entry FIFO; rd_valid = FIFO non-empty, pop on rd_valid&rd_ready; order preserved; full throughput (1 word/cycle) with rd_ready held high.
REQ-017 SHALL increment address by 1 per access, wrapping 1023->0 (mod 2^ADDR_W).
REQ-018 SHALL decrement remaining count per access; after the last write go IDLE and pulse done; after the last read issue go DRAIN, then IDLE with done pulse on the cycle the final word pops.
REQ-019 SHALL drive avm_clken=1 whenever reset_n=1; avm_chipselect=0 in IDLE and DRAIN.
REQ-020 SHALL ignore wr_valid outside WRITE (wr_ready=0).

Reset
REQ-021 SHALL on reset_n=0, asynchronously: state IDLE, FIFO empty, cmd_ready=1 after release, rd_valid=0, done=0, avm_chipselect=0, avm_write=0, avm_clken=0, address/count=0.
REQ-022 SHALL abandon any in-flight command on mid-operation reset; no done pulse, captured read data discarded.

Configuration
REQ-023 SHALL support macro ONCHIP_MEM_MASTER_RANGECHK_EN: when defined, adds output err (1 bit); command with cmd_addr+cmd_len > 2^ADDR_W is accepted, issues no access, pulses err and done together next cycle; when undefined, no err port and addresses wrap per REQ-017.

Structure
REQ-024 SHALL place state enum, ADDR_W/DATA_W/LEN_W defaults and RAM depth constant in package onchip_mem_pkg.
REQ-025 SHALL implement the 2-entry read buffer as sub-module onchip_mem_rd_skid.

Verification
REQ-026 SHALL cover: write addr=5 len=4 data 0xA0..0xA3, be=0xF -> 4 consecutive write cycles addr 5..8, done pulse after 4th.
REQ-027 SHALL cover: read addr=5 len=4, rd_ready=1 -> rd_data 0xA0..0xA3 on 4 consecutive cycles, first word 2 cycles after accept, done with last pop.
REQ-028 SHALL cover: read len=8 with rd_ready toggling 1/0 -> no word lost/duplicated, never >2 buffered.
REQ-029 SHALL cover: write addr=1022 len=4 -> addresses 1022,1023,0,1 (macro off); macro on -> err+done, no chipselect.
REQ-030 SHALL cover: reset_n low during read at word 3 of 8 -> chipselect low immediately, rd_valid=0, no done, next command accepted normally.
REQ-031 SHALL cover: cmd_len=0 -> done next cycle, no avm activity.
